// File: rtl/cpu_decoder_types_pkg.sv
// Shared decoder types: block-transfer FSM states, decoded LDM/STM fields and
// the footprint helper used to place the transfer window in memory.
package cpu_decoder_types_pkg;

   typedef enum logic [1:0] {
      BX_IDLE   = 2'd0,
      BX_XFER   = 2'd1,
      BX_FINISH = 2'd2
   } block_xfer_state_t;

   typedef struct packed {
      logic is_load;
      logic p;
      logic u;
      logic s;
      logic w;
   } block_xfer_fields_t;

   // An empty list still transfers r15 but occupies a 16-word window.
   localparam logic [15:0] EMPTY_LIST_MASK = 16'h8000;

   function automatic logic [31:0] block_bytes(input logic [15:0] list);
      logic [4:0] cnt;
      cnt = '0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + {4'd0, list[i]};
      end
      if (list == 16'h0000) begin
         return 32'd64;
      end
      return {25'd0, cnt, 2'b00};
   endfunction

endpackage

// File: rtl/arm_lsb_encoder.sv
// Lowest-set-bit priority encoder over a 16-bit register mask.
module arm_lsb_encoder (
   input  logic [15:0] mask,
   output logic [3:0]  idx,
   output logic        valid
);

   always_comb begin
      idx   = 4'd0;
      valid = 1'b0;
      // Scanning downward lets the lowest set bit win the last assignment.
      for (int i = 15; i >= 0; i--) begin
         if (mask[i]) begin
            idx   = 4'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arm_block_xfer_seq.sv
// LDM/STM beat sequencer: walks the register list lowest-first at ascending
// word addresses, then issues the done pulse and optional base writeback.
module arm_block_xfer_seq
   import cpu_decoder_types_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_load,
   input  logic        P,
   input  logic        U,
   input  logic        S,
   input  logic        W,
   input  logic [3:0]  rn_idx,
   input  logic [31:0] rn_value,
   input  logic [15:0] reg_list,
   output logic        busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   output logic [3:0]  xfer_reg,
   output logic        user_bank,
   output logic        wb_en,
   output logic [31:0] wb_value,
   output logic        done
);

   block_xfer_state_t  state_q, state_d;
   block_xfer_fields_t fields_in;

   logic        busy_q, busy_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  reg_q, reg_d;
   logic [15:0] mask_q, mask_d;
   logic        user_q, user_d;
   logic        wb_en_q, wb_en_d;
   logic [31:0] wb_value_q, wb_value_d;
   logic        done_q, done_d;
   logic        is_load_q, is_load_d;
   logic        w_q, w_d;
   logic        rn_in_list_q, rn_in_list_d;

   logic [15:0] eff_list;
   logic [15:0] enc_mask;
   logic [3:0]  enc_idx;
   logic        enc_valid;
   logic [31:0] nbytes;
   logic [31:0] first_addr;
   logic [31:0] wb_calc;

   assign fields_in = '{is_load: is_load, p: P, u: U, s: S, w: W};
   assign eff_list  = (reg_list == 16'h0000) ? EMPTY_LIST_MASK : reg_list;
   assign nbytes    = block_bytes(reg_list);
   assign wb_calc   = fields_in.u ? (rn_value + nbytes) : (rn_value - nbytes);

   always_comb begin
      case ({fields_in.p, fields_in.u})
         2'b01:   first_addr = rn_value;
         2'b11:   first_addr = rn_value + 32'd4;
         2'b00:   first_addr = rn_value - nbytes + 32'd4;
         default: first_addr = rn_value - nbytes;
      endcase
   end

   // In IDLE the encoder looks at the incoming list; during XFER it looks at
   // the bits not yet served, so its valid flag also marks "more beats left".
   assign enc_mask = (state_q == BX_IDLE) ? eff_list : mask_q;

   arm_lsb_encoder u_lsb_encoder (
      .mask  (enc_mask),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   always_comb begin
      state_d      = state_q;
      busy_d       = busy_q;
      req_d        = req_q;
      we_d         = we_q;
      addr_d       = addr_q;
      reg_d        = reg_q;
      mask_d       = mask_q;
      user_d       = user_q;
      wb_en_d      = 1'b0;
      wb_value_d   = wb_value_q;
      done_d       = 1'b0;
      is_load_d    = is_load_q;
      w_d          = w_q;
      rn_in_list_d = rn_in_list_q;

      case (state_q)
         BX_IDLE: begin
            if (start) begin
               state_d      = BX_XFER;
               busy_d       = 1'b1;
               req_d        = 1'b1;
               we_d         = ~fields_in.is_load;
               addr_d       = {first_addr[31:2], 2'b00};
               reg_d        = enc_idx;
               mask_d       = eff_list & ~(16'h0001 << enc_idx);
               user_d       = fields_in.s;
               wb_value_d   = wb_calc;
               is_load_d    = fields_in.is_load;
               w_d          = fields_in.w;
               rn_in_list_d = reg_list[rn_idx];
            end
         end
         BX_XFER: begin
            if (mem_ack) begin
               if (enc_valid) begin
                  addr_d = addr_q + 32'd4;
                  reg_d  = enc_idx;
                  mask_d = mask_q & ~(16'h0001 << enc_idx);
               end else begin
                  state_d = BX_FINISH;
                  req_d   = 1'b0;
                  we_d    = 1'b0;
                  done_d  = 1'b1;
                  // A load that overwrites the base keeps the loaded value.
                  wb_en_d = w_q & ~(is_load_q & rn_in_list_q);
               end
            end
         end
         BX_FINISH: begin
            state_d = BX_IDLE;
            busy_d  = 1'b0;
            user_d  = 1'b0;
         end
         default: begin
            state_d = BX_IDLE;
            busy_d  = 1'b0;
            req_d   = 1'b0;
            we_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= BX_IDLE;
         busy_q       <= 1'b0;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= 32'd0;
         reg_q        <= 4'd0;
         mask_q       <= 16'd0;
         user_q       <= 1'b0;
         wb_en_q      <= 1'b0;
         wb_value_q   <= 32'd0;
         done_q       <= 1'b0;
         is_load_q    <= 1'b0;
         w_q          <= 1'b0;
         rn_in_list_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         req_q        <= req_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         reg_q        <= reg_d;
         mask_q       <= mask_d;
         user_q       <= user_d;
         wb_en_q      <= wb_en_d;
         wb_value_q   <= wb_value_d;
         done_q       <= done_d;
         is_load_q    <= is_load_d;
         w_q          <= w_d;
         rn_in_list_q <= rn_in_list_d;
      end
   end

   assign busy      = busy_q;
   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign xfer_reg  = reg_q;
   assign user_bank = user_q;
   assign wb_en     = wb_en_q;
   assign wb_value  = wb_value_q;
   assign done      = done_q;

endmodule

// File: tb/tb_arm_block_xfer_seq.sv
// Directed and randomized checks of the LDM/STM sequencer against a
// window-based model of where each beat must land.
module tb_arm_block_xfer_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        is_load = 1'b0;
   logic        P = 1'b0;
   logic        U = 1'b0;
   logic        S = 1'b0;
   logic        W = 1'b0;
   logic [3:0]  rn_idx = 4'd0;
   logic [31:0] rn_value = 32'd0;
   logic [15:0] reg_list = 16'd0;
   logic        mem_ack = 1'b0;
   logic        busy, mem_req, mem_we, user_bank, wb_en, done;
   logic [31:0] mem_addr, wb_value;
   logic [3:0]  xfer_reg;

   int checks = 0;
   int passed = 0;
   int failed = 0;

   arm_block_xfer_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .is_load   (is_load),
      .P         (P),
      .U         (U),
      .S         (S),
      .W         (W),
      .rn_idx    (rn_idx),
      .rn_value  (rn_value),
      .reg_list  (reg_list),
      .busy      (busy),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .xfer_reg  (xfer_reg),
      .user_bank (user_bank),
      .wb_en     (wb_en),
      .wb_value  (wb_value),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".busy"},      {31'd0, busy},      32'd0);
      check({tag, ".mem_req"},   {31'd0, mem_req},   32'd0);
      check({tag, ".mem_we"},    {31'd0, mem_we},    32'd0);
      check({tag, ".user_bank"}, {31'd0, user_bank}, 32'd0);
      check({tag, ".wb_en"},     {31'd0, wb_en},     32'd0);
      check({tag, ".done"},      {31'd0, done},      32'd0);
      check({tag, ".mem_addr"},  mem_addr,           32'd0);
      check({tag, ".wb_value"},  wb_value,           32'd0);
      check({tag, ".xfer_reg"},  {28'd0, xfer_reg},  32'd0);
   endtask

   // Model: the transfer occupies a contiguous window of words; beats fill it
   // from its lowest word in ascending register order.
   task automatic run_xfer(input string name, input logic ld, input logic p, input logic u,
                           input logic s, input logic w, input logic [3:0] ri,
                           input logic [31:0] rn, input logic [15:0] list, input bit rand_ack);
      logic [3:0]  exp_reg[$];
      logic [31:0] exp_addr[$];
      logic [31:0] lo, hi, wbv, words;
      logic        wbe;
      int          k, cyc;

      for (int i = 0; i < 16; i++) begin
         if (list[i]) exp_reg.push_back(4'(i));
      end
      if (exp_reg.size() == 0) exp_reg.push_back(4'd15);
      words = (list == 16'd0) ? 32'd16 : 32'(exp_reg.size());
      if (u) begin
         lo = p ? rn + 32'd4 : rn;
      end else begin
         hi = p ? rn - 32'd4 : rn;
         lo = hi - 32'd4 * (words - 32'd1);
      end
      for (int i = 0; i < exp_reg.size(); i++) begin
         exp_addr.push_back((lo + 32'd4 * 32'(i)) & 32'hFFFF_FFFC);
      end
      wbv = u ? rn + 32'd4 * words : rn - 32'd4 * words;
      wbe = w && !(ld && list[ri]);

      is_load = ld; P = p; U = u; S = s; W = w;
      rn_idx = ri; rn_value = rn; reg_list = list; start = 1'b1;
      tick();
      start = 1'b0;
      // Scramble inputs to prove everything was latched at start.
      rn_value = $urandom; reg_list = 16'($urandom); rn_idx = 4'($urandom);
      P = ~p; U = ~u; S = ~s; W = ~w; is_load = ~ld;

      cyc = 1;
      k = 0;
      while (k < exp_reg.size() && cyc < 2000) begin
         check({name, ".busy"},      {31'd0, busy},      32'd1);
         check({name, ".mem_req"},   {31'd0, mem_req},   32'd1);
         check({name, ".mem_addr"},  mem_addr,           exp_addr[k]);
         check({name, ".xfer_reg"},  {28'd0, xfer_reg},  {28'd0, exp_reg[k]});
         check({name, ".mem_we"},    {31'd0, mem_we},    {31'd0, ~ld});
         check({name, ".user_bank"}, {31'd0, user_bank}, {31'd0, s});
         check({name, ".done"},      {31'd0, done},      32'd0);
         mem_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         if (mem_ack) k++;
         cyc++;
      end
      mem_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b0;
      check({name, ".no_timeout"}, {31'd0, 1'(cyc < 2000)}, 32'd1);
      check({name, ".fin_mem_req"}, {31'd0, mem_req}, 32'd0);
      check({name, ".fin_done"},    {31'd0, done},    32'd1);
      check({name, ".fin_busy"},    {31'd0, busy},    32'd1);
      check({name, ".fin_wb_en"},   {31'd0, wb_en},   {31'd0, wbe});
      check({name, ".fin_wb_val"},  wb_value,         wbv);
      if (!rand_ack) check({name, ".latency"}, 32'(cyc), 32'(exp_reg.size() + 1));
      tick();
      mem_ack = 1'b0;
      check({name, ".post_busy"},  {31'd0, busy},  32'd0);
      check({name, ".post_done"},  {31'd0, done},  32'd0);
      check({name, ".post_wb_en"}, {31'd0, wb_en}, 32'd0);
      check({name, ".post_req"},   {31'd0, mem_req}, 32'd0);
      $display("xfer %s ld=%0d P=%0d U=%0d W=%0d rn=%h list=%h beats=%0d cycles=%0d wb=%h wb_en=%0d",
               name, ld, p, u, w, rn, list, exp_reg.size(), cyc, wbv, wbe);
   endtask

   initial begin
      #2;
      check_all_zero("reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check_all_zero("idle");

      run_xfer("stmia",      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0300_0000, 16'h000F, 1'b0);
      run_xfer("ldmdb",      1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 32'h0300_0100, 16'h8001, 1'b0);
      run_xfer("ldmia_base", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 32'h0000_2000, 16'h0004, 1'b0);
      run_xfer("stmib_empty",1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 32'h0200_0000, 16'h0000, 1'b0);
      run_xfer("stmda_low",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0000_0004, 16'h0003, 1'b0);
      run_xfer("stmdb_wrap", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0000_0004, 16'h0003, 1'b0);
      run_xfer("ldmda_empty",1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 32'h0000_1000, 16'h0000, 1'b1);

      // Stall on beat 2, stray start while busy, then reset mid-beat.
      is_load = 1'b0; P = 1'b0; U = 1'b1; S = 1'b0; W = 1'b1;
      rn_idx = 4'd0; rn_value = 32'h0000_1000; reg_list = 16'h00F0; start = 1'b1;
      tick();
      start = 1'b0;
      check("stall.beat1_addr", mem_addr, 32'h0000_1000);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("stall.hold_addr", mem_addr, 32'h0000_1004);
         check("stall.hold_reg",  {28'd0, xfer_reg}, 32'd5);
         check("stall.hold_req",  {31'd0, mem_req},  32'd1);
         if (i == 1) begin
            is_load = 1'b1; rn_value = 32'h0000_5000; reg_list = 16'h0001; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      check("stall.still_beat2", mem_addr, 32'h0000_1004);
      check("stall.we_kept",     {31'd0, mem_we}, 32'd1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("stall.beat3_addr", mem_addr, 32'h0000_1008);
      check("stall.beat3_reg",  {28'd0, xfer_reg}, 32'd6);
      rst_n = 1'b0;
      #1;
      check_all_zero("abort");
      for (int i = 0; i < 3; i++) begin
         mem_ack = 1'b1;
         tick();
         check("abort.done",  {31'd0, done},  32'd0);
         check("abort.wb_en", {31'd0, wb_en}, 32'd0);
      end
      mem_ack = 1'b0;
      rst_n = 1'b1;
      tick();
      check_all_zero("abort_release");
      $display("xfer stall_abort stall=3 stray_start=1 reset_mid_beat=1");

      for (int t = 0; t < 24; t++) begin
         logic [15:0] list;
         case ($urandom_range(0, 7))
            0:       list = 16'h0000;
            1:       list = 16'h0001 << $urandom_range(0, 15);
            default: list = 16'($urandom);
         endcase
         run_xfer($sformatf("rand%0d", t), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 4'($urandom), $urandom, list, t[0]);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
